// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the sync_fifo_ctrl block.
//   fifo_mode_e - read-path mode: standard registered read or first-word-fall-through.
//   cnt_width   - width of an occupancy counter that can represent 0..depth inclusive.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH simple dual-port register array.
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - asynchronous read data
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and a standard or first-word-fall-through read path.
//   clk, rst         - clock, asynchronous active-high reset
//   i_wr_en, i_wr_data - write request and data
//   i_rd_en          - read request (STD) / pop of head word (FWFT)
//   o_rd_data        - read data (registered in STD, head of queue in FWFT)
//   o_rd_valid       - STD: one-cycle pulse per accepted read; FWFT: !empty
//   o_full, o_empty, o_almost_full, o_almost_empty - registered status flags
//   o_count          - current occupancy
//   o_overflow, o_underflow - one-cycle pulses for rejected write/read requests
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 1,
  parameter fifo_mode_e  MODE      = FIFO_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [WIDTH-1:0]              i_wr_data,
  input  logic                          i_rd_en,
  output logic [WIDTH-1:0]              o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_ctrl: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_ctrl: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic             w_wr_acc, w_rd_acc;
  logic [CW-1:0]    w_count_d;
  logic [WIDTH-1:0] w_mem_rdata;

  // Acceptance uses the registered flags, so no request input reaches a flag combinationally.
  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & ~r_empty;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Flags are computed from the next count so they change on the same edge as the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_d;
      r_full   <= (w_count_d == CW'(DEPTH));
      r_empty  <= (w_count_d == '0);
      r_afull  <= (w_count_d >= CW'(AFULL_TH));
      r_aempty <= (w_count_d <= CW'(AEMPTY_TH));
      r_ovf    <= i_wr_en & r_full;
      r_udf    <= i_rd_en & r_empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_mem_rdata;
      end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
  end else begin : g_fwft
    // Head word is presented directly from the array; a read request pops it.
    assign o_rd_data  = w_mem_rdata;
    assign o_rd_valid = ~r_empty;
  end

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_afull;
  assign o_almost_empty = r_aempty;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule
